// File: rtl/rfsoc_regs_pkg.sv
// rfsoc_regs_pkg: register map constants, bit positions and shared types for
// the rfsoc_chan_regs capture-channel register bank.
package rfsoc_regs_pkg;

    // Identification word returned at offset 0x000
    localparam logic [31:0] VERSION = 32'h0001_0000;

    // Global register offsets (bytes)
    localparam int unsigned OFF_VERSION  = 32'h000;
    localparam int unsigned OFF_IRQ_EN   = 32'h004;
    localparam int unsigned OFF_IRQ_STAT = 32'h008;
    localparam int unsigned OFF_HOLDOFF  = 32'h00C;

    // Register offsets inside one channel window (bytes)
    localparam int unsigned CH_START_ADDR = 32'h00;
    localparam int unsigned CH_CAP_SIZE   = 32'h04;
    localparam int unsigned CH_CTRL       = 32'h08;
    localparam int unsigned CH_STATUS     = 32'h0C;
    localparam int unsigned CH_CUR_ADDR   = 32'h10;
    localparam int unsigned CH_DONE_CNT   = 32'h14;

    // CTRL / STATUS bit positions
    localparam int unsigned CTRL_START_BIT = 0;
    localparam int unsigned CTRL_RESET_BIT = 1;
    localparam int unsigned STAT_BUSY_BIT  = 0;
    localparam int unsigned STAT_ERR_BIT   = 1;
    localparam int unsigned STAT_OVR_BIT   = 2;

    // IRQ_EN / IRQ_STAT layout: done bits from 0, err bits from 16, global enable at 31
    localparam int unsigned IRQ_ERR_LSB = 16;
    localparam int unsigned IRQ_GEN_BIT = 31;

    typedef struct packed {
        logic [31:0] start_addr;
        logic [31:0] cap_size;
    } ch_cfg_t;

    // Expand 4 byte enables into a 32-bit bit mask
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

    // Implemented IRQ_EN bits for a given channel count
    function automatic logic [31:0] irq_valid_mask(input int unsigned nch);
        logic [31:0] m;
        m = 32'h8000_0000;
        for (int unsigned i = 0; i < nch; i++) begin
            m = m | (32'd1 << i) | (32'd1 << (IRQ_ERR_LSB + i));
        end
        return m;
    endfunction

endpackage

// File: rtl/rfsoc_chan_ctrl.sv
// rfsoc_chan_ctrl: one capture channel's register window. Holds the start
// address / capture size configuration, start gating with overrun detection,
// the level reset, the saturating done counter and the error rising-edge detect.
module rfsoc_chan_ctrl
    import rfsoc_regs_pkg::*;
#(
    parameter int unsigned AW = 16
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          sel,          // offset falls inside this window
    input  logic          wren,
    input  logic [AW-1:0] loc_off,      // byte offset relative to window base
    input  logic [31:0]   wdata,
    input  logic [3:0]    wstrb,
    output logic [31:0]   rd_word,      // read value at loc_off (unqualified by sel)
    output logic [31:0]   start_addr,
    output logic [31:0]   cap_size,
    output logic          start,
    output logic          reset_lvl,
    output logic          err_rise,
    input  logic          busy,
    input  logic          done,
    input  logic          err,
    input  logic [31:0]   cur_addr
);

    localparam logic [AW-1:0] A_START  = AW'(CH_START_ADDR);
    localparam logic [AW-1:0] A_SIZE   = AW'(CH_CAP_SIZE);
    localparam logic [AW-1:0] A_CTRL   = AW'(CH_CTRL);
    localparam logic [AW-1:0] A_STATUS = AW'(CH_STATUS);
    localparam logic [AW-1:0] A_CUR    = AW'(CH_CUR_ADDR);
    localparam logic [AW-1:0] A_DONE   = AW'(CH_DONE_CNT);

    ch_cfg_t     cfg_q, cfg_d;
    logic        start_q, start_d;
    logic        reset_q, reset_d;
    logic        ovr_q, ovr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q;
    logic [31:0] wmask;
    logic        start_req;
    logic        start_ok;

    // Next-state for config, CTRL, overrun and done counter
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves it unassigned (no latch).
        cfg_d     = cfg_q;
        reset_d   = reset_q;
        ovr_d     = ovr_q;
        cnt_d     = cnt_q;
        start_req = 1'b0;
        wmask     = strb_mask(wstrb);
        if (sel && wren) begin
            case (loc_off)
                A_START: cfg_d.start_addr = (cfg_q.start_addr & ~wmask) | (wdata & wmask);
                A_SIZE:  cfg_d.cap_size   = (cfg_q.cap_size & ~wmask) | (wdata & wmask);
                A_CTRL: begin
                    if (wstrb[0]) begin
                        start_req = wdata[CTRL_START_BIT];
                        reset_d   = wdata[CTRL_RESET_BIT];
                        if (wdata[CTRL_RESET_BIT]) begin
                            ovr_d = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
        // Gating uses the reset level in force before this write
        start_ok = start_req && !busy && !reset_q;
        start_d  = start_ok;
        // A refused start is recorded even if the same write clears the flag
        if (start_req && !start_ok) begin
            ovr_d = 1'b1;
        end
        // Software clear takes priority over a coincident done pulse
        if (sel && wren && (loc_off == A_DONE)) begin
            cnt_d = '0;
        end else if (done && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // State registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rstb) begin
        // NOTE: every register, counters included, is reset so the bank reads all-zero after reset.
        if (!rstb) begin
            cfg_q   <= '0;
            start_q <= 1'b0;
            reset_q <= 1'b0;
            ovr_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            cfg_q   <= cfg_d;
            start_q <= start_d;
            reset_q <= reset_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
            err_q   <= err;
        end
    end

    // Read view of the window
    always_comb begin
        rd_word = '0;
        case (loc_off)
            A_START:  rd_word = cfg_q.start_addr;
            A_SIZE:   rd_word = cfg_q.cap_size;
            A_CTRL:   rd_word[CTRL_RESET_BIT] = reset_q;
            A_STATUS: begin
                rd_word[STAT_BUSY_BIT] = busy;
                rd_word[STAT_ERR_BIT]  = err;
                rd_word[STAT_OVR_BIT]  = ovr_q;
            end
            A_CUR:    rd_word = cur_addr;
            A_DONE:   rd_word = {16'd0, cnt_q};
            default:  rd_word = '0;
        endcase
    end

    assign start_addr = cfg_q.start_addr;
    assign cap_size   = cfg_q.cap_size;
    assign start      = start_q;
    assign reset_lvl  = reset_q;
    assign err_rise   = err && !err_q;

endmodule

// File: rtl/rfsoc_chan_regs.sv
// rfsoc_chan_regs: PS-bus control/status register bank for NCH capture channels.
// Decodes global and per-channel windows, aggregates done/error events into a
// W1C interrupt status and drives a registered irq.
// Optional build macro RFSOC_CHAN_REGS_IRQ_COALESCE_EN adds the HOLDOFF register
// and an interrupt coalescing timer.
module rfsoc_chan_regs
    import rfsoc_regs_pkg::*;
#(
    parameter int unsigned NCH       = 4,
    parameter int unsigned AW        = 16,
    parameter int unsigned CH_BASE   = 32'h0100,
    parameter int unsigned CH_STRIDE = 32'h0020
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               wren,
    input  logic               rden,
    input  logic [AW-1:0]      offset,
    input  logic [31:0]        wdata,
    input  logic [3:0]         wstrb,
    output logic [31:0]        rdata,
    output logic               rvalid,
    output logic [NCH*32-1:0]  ch_start_addr,
    output logic [NCH*32-1:0]  ch_cap_size,
    output logic [NCH-1:0]     ch_start,
    output logic [NCH-1:0]     ch_reset,
    input  logic [NCH-1:0]     ch_busy,
    input  logic [NCH-1:0]     ch_done,
    input  logic [NCH-1:0]     ch_err,
    input  logic [NCH*32-1:0]  ch_cur_addr,
    output logic               irq
);

    localparam logic [AW-1:0] A_VERSION  = AW'(OFF_VERSION);
    localparam logic [AW-1:0] A_IRQ_EN   = AW'(OFF_IRQ_EN);
    localparam logic [AW-1:0] A_IRQ_STAT = AW'(OFF_IRQ_STAT);
    localparam logic [AW-1:0] A_HOLDOFF  = AW'(OFF_HOLDOFF);
    localparam logic [31:0]   EN_MASK    = irq_valid_mask(NCH);
    localparam logic [31:0]   STAT_MASK  = EN_MASK & 32'h7FFF_FFFF;

    logic [NCH-1:0] ch_sel;
    logic [NCH-1:0] err_rise;
    logic [31:0]    ch_rd_word [NCH];

    logic [31:0] wmask;
    logic [31:0] w1c;
    logic [31:0] irq_set;
    logic [31:0] irq_en_q, irq_en_d;
    logic [31:0] irq_stat_q, irq_stat_d;
    logic        pending;
    logic        irq_q, irq_d;
    logic [31:0] rd_word;
    logic [31:0] rdata_q;
    logic        rvalid_q;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        localparam logic [AW-1:0] WIN_BASE = AW'(CH_BASE + c * CH_STRIDE);
        logic [AW-1:0] loc_off;

        assign loc_off   = offset - WIN_BASE;
        assign ch_sel[c] = (offset >= WIN_BASE) && (32'(loc_off) < CH_STRIDE);

        rfsoc_chan_ctrl #(
            .AW (AW)
        ) u_chan (
            .clk        (clk),
            .rstb       (rstb),
            .sel        (ch_sel[c]),
            .wren       (wren),
            .loc_off    (loc_off),
            .wdata      (wdata),
            .wstrb      (wstrb),
            .rd_word    (ch_rd_word[c]),
            .start_addr (ch_start_addr[32*c +: 32]),
            .cap_size   (ch_cap_size[32*c +: 32]),
            .start      (ch_start[c]),
            .reset_lvl  (ch_reset[c]),
            .err_rise   (err_rise[c]),
            .busy       (ch_busy[c]),
            .done       (ch_done[c]),
            .err        (ch_err[c]),
            .cur_addr   (ch_cur_addr[32*c +: 32])
        );
    end

    // IRQ enable/status next-state; a new event wins over a coincident W1C
    always_comb begin
        wmask    = strb_mask(wstrb);
        irq_en_d = irq_en_q;
        w1c      = '0;
        irq_set  = '0;
        if (wren && (offset == A_IRQ_EN)) begin
            irq_en_d = ((irq_en_q & ~wmask) | (wdata & wmask)) & EN_MASK;
        end
        if (wren && (offset == A_IRQ_STAT)) begin
            w1c = wdata & wmask;
        end
        irq_set[NCH-1:0]            = ch_done;
        irq_set[IRQ_ERR_LSB +: NCH] = err_rise;
        irq_stat_d = ((irq_stat_q & ~w1c) | irq_set) & STAT_MASK;
    end

    assign pending = irq_en_q[IRQ_GEN_BIT] && (|(irq_stat_q[30:0] & irq_en_q[30:0]));

`ifdef RFSOC_CHAN_REGS_IRQ_COALESCE_EN
    logic [15:0] holdoff_q, holdoff_d;
    logic [15:0] timer_q, timer_d;
    logic        pend_q;

    // Holdoff register and coalescing timer: irq waits HOLDOFF cycles after pending rises
    always_comb begin
        holdoff_d = holdoff_q;
        timer_d   = '0;
        irq_d     = 1'b0;
        if (wren && (offset == A_HOLDOFF)) begin
            holdoff_d = (holdoff_q & ~wmask[15:0]) | (wdata[15:0] & wmask[15:0]);
        end
        if (pending) begin
            if (!pend_q) begin
                timer_d = holdoff_q;
                irq_d   = (holdoff_q == 16'd0);
            end else begin
                timer_d = (timer_q != 16'd0) ? (timer_q - 16'd1) : 16'd0;
                irq_d   = (timer_q <= 16'd1);
            end
        end
    end

    // Coalescing state registers
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            holdoff_q <= '0;
            timer_q   <= '0;
            pend_q    <= 1'b0;
        end else begin
            holdoff_q <= holdoff_d;
            timer_q   <= timer_d;
            pend_q    <= pending;
        end
    end
`else
    assign irq_d = pending;
`endif

    // Read mux over global registers and the selected channel window
    always_comb begin
        rd_word = '0;
        case (offset)
            A_VERSION:  rd_word = VERSION;
            A_IRQ_EN:   rd_word = irq_en_q;
            A_IRQ_STAT: rd_word = irq_stat_q;
`ifdef RFSOC_CHAN_REGS_IRQ_COALESCE_EN
            A_HOLDOFF:  rd_word = {16'd0, holdoff_q};
`else
            A_HOLDOFF:  rd_word = '0;
`endif
            default: begin
                for (int unsigned c = 0; c < NCH; c++) begin
                    if (ch_sel[c]) begin
                        rd_word = rd_word | ch_rd_word[c];
                    end
                end
            end
        endcase
    end

    // IRQ and read-response registers
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            irq_en_q   <= '0;
            irq_stat_q <= '0;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            irq_en_q   <= irq_en_d;
            irq_stat_q <= irq_stat_d;
            irq_q      <= irq_d;
            rvalid_q   <= rden;
            if (rden) begin
                rdata_q <= rd_word;
            end
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign irq    = irq_q;

endmodule

// File: tb/tb_rfsoc_chan_regs.sv
// tb_rfsoc_chan_regs: directed bench for rfsoc_chan_regs. Reads push their
// expected data into a scoreboard queue; a negedge monitor pops and compares
// whenever rvalid is seen. Side-band outputs are compared directly with check().
module tb_rfsoc_chan_regs;

    localparam int NCH = 4;
    localparam int AW  = 16;

    logic              clk = 1'b0;
    logic              rstb = 1'b0;
    logic              wren = 1'b0;
    logic              rden = 1'b0;
    logic [AW-1:0]     offset = '0;
    logic [31:0]       wdata = '0;
    logic [3:0]        wstrb = '0;
    logic [31:0]       rdata;
    logic              rvalid;
    logic [NCH*32-1:0] ch_start_addr;
    logic [NCH*32-1:0] ch_cap_size;
    logic [NCH-1:0]    ch_start;
    logic [NCH-1:0]    ch_reset;
    logic [NCH-1:0]    ch_busy = '0;
    logic [NCH-1:0]    ch_done = '0;
    logic [NCH-1:0]    ch_err = '0;
    logic [NCH*32-1:0] ch_cur_addr = '0;
    logic              irq;

    int          n_checks = 0;
    int          n_fail = 0;
    string       exp_name [$];
    logic [31:0] exp_data [$];
    string       mon_name;
    logic [31:0] mon_exp;
    logic        irq_seen;

    always #5 clk = ~clk;

    rfsoc_chan_regs #(
        .NCH       (NCH),
        .AW        (AW),
        .CH_BASE   (32'h0100),
        .CH_STRIDE (32'h0020)
    ) dut (
        .clk           (clk),
        .rstb          (rstb),
        .wren          (wren),
        .rden          (rden),
        .offset        (offset),
        .wdata         (wdata),
        .wstrb         (wstrb),
        .rdata         (rdata),
        .rvalid        (rvalid),
        .ch_start_addr (ch_start_addr),
        .ch_cap_size   (ch_cap_size),
        .ch_start      (ch_start),
        .ch_reset      (ch_reset),
        .ch_busy       (ch_busy),
        .ch_done       (ch_done),
        .ch_err        (ch_err),
        .ch_cur_addr   (ch_cur_addr),
        .irq           (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every rvalid must match the oldest outstanding read
    always @(negedge clk) begin
        if (rvalid) begin
            if (exp_data.size() == 0) begin
                check("unexpected rvalid", {31'd0, rvalid}, 32'd0);
            end else begin
                mon_name = exp_name.pop_front();
                mon_exp  = exp_data.pop_front();
                check(mon_name, rdata, mon_exp);
            end
        end
    end

    task automatic reg_write(input logic [AW-1:0] off, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        offset = off;
        wdata  = d;
        wstrb  = s;
        wren   = 1'b1;
        @(negedge clk);
        wren   = 1'b0;
        wstrb  = '0;
    endtask

    task automatic reg_read(input string name, input logic [AW-1:0] off, input logic [31:0] e);
        @(negedge clk);
        offset = off;
        rden   = 1'b1;
        exp_name.push_back(name);
        exp_data.push_back(e);
        @(negedge clk);
        rden = 1'b0;
        @(negedge clk);
        check({name, " rvalid one cycle"}, {31'd0, rvalid}, 32'd0);
    endtask

    task automatic pulse_done(input int ch);
        @(negedge clk);
        ch_done[ch] = 1'b1;
        @(negedge clk);
        ch_done[ch] = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst rdata", rdata, 32'd0);
        check("rst rvalid", {31'd0, rvalid}, 32'd0);
        check("rst irq", {31'd0, irq}, 32'd0);
        check("rst ch_start", {28'd0, ch_start}, 32'd0);
        check("rst ch_reset", {28'd0, ch_reset}, 32'd0);
        check("rst cfg ports", {31'd0, (|ch_start_addr) | (|ch_cap_size)}, 32'd0);
        rstb = 1'b1;

        // Byte-strobed config writes
        reg_write(16'h0100, 32'hDEADBEEF, 4'h3);
        reg_read("ch0 start_addr strb3", 16'h0100, 32'h0000BEEF);
        check("ch0 start_addr port", ch_start_addr[31:0], 32'h0000BEEF);
        reg_write(16'h0124, 32'h12345678, 4'hF);
        reg_write(16'h0124, 32'hAB000000, 4'h8);
        reg_read("ch1 cap_size byte3", 16'h0124, 32'hAB345678);
        check("ch1 cap_size port", ch_cap_size[63:32], 32'hAB345678);
        reg_read("version", 16'h0000, 32'h0001_0000);

        // Start pulse, refused starts and overrun
        reg_write(16'h0128, 32'h1, 4'h1);
        check("ch1 start pulse", {28'd0, ch_start}, 32'h2);
        @(negedge clk);
        check("ch1 start one cycle", {28'd0, ch_start}, 32'h0);
        reg_read("ch1 status idle", 16'h012C, 32'h0);
        ch_busy[1] = 1'b1;
        reg_write(16'h0128, 32'h1, 4'h1);
        check("ch1 start while busy", {28'd0, ch_start}, 32'h0);
        reg_read("ch1 status busy ovr", 16'h012C, 32'h5);
        reg_write(16'h0128, 32'h2, 4'h1);
        check("ch1 reset level", {28'd0, ch_reset}, 32'h2);
        reg_read("ch1 status ovr cleared", 16'h012C, 32'h1);
        reg_read("ch1 ctrl readback", 16'h0128, 32'h2);
        ch_busy[1] = 1'b0;
        reg_write(16'h0128, 32'h1, 4'h1);
        check("ch1 start while reset", {28'd0, ch_start}, 32'h0);
        reg_read("ch1 status ovr from reset", 16'h012C, 32'h4);

        // Live current address
        ch_cur_addr[96 +: 32] = 32'hCAFE0010;
        reg_read("ch3 cur_addr", 16'h0170, 32'hCAFE0010);

        // Error edge detect into IRQ_STAT
        ch_err[2] = 1'b1;
        repeat (10) @(negedge clk);
        reg_read("ch2 status err", 16'h014C, 32'h2);
        reg_read("irq_stat err edge", 16'h0008, 32'h0004_0000);
        reg_write(16'h0008, 32'h0004_0000, 4'hF);
        reg_read("irq_stat err set once", 16'h0008, 32'h0);
        check("irq off while disabled", {31'd0, irq}, 32'd0);
        ch_err[2] = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        ch_err[2] = 1'b1;
        offset = 16'h0008;
        wdata  = 32'h0004_0000;
        wstrb  = 4'hF;
        wren   = 1'b1;
        @(negedge clk);
        wren   = 1'b0;
        wstrb  = '0;
        reg_read("irq_stat set beats w1c", 16'h0008, 32'h0004_0000);
        reg_write(16'h0008, 32'h0004_0000, 4'hF);
        ch_err[2] = 1'b0;

        // Done counter and interrupt
        reg_write(16'h0004, 32'h8000_0001, 4'hF);
        reg_read("irq_en readback", 16'h0004, 32'h8000_0001);
        pulse_done(0);
        pulse_done(0);
        pulse_done(0);
        reg_read("ch0 done_cnt", 16'h0114, 32'd3);
        check("irq asserted", {31'd0, irq}, 32'd1);
        reg_read("irq_stat done", 16'h0008, 32'h1);
        reg_write(16'h0008, 32'h1, 4'hF);
        check("irq after w1c edge", {31'd0, irq}, 32'd1);
        @(negedge clk);
        check("irq cleared", {31'd0, irq}, 32'd0);
        reg_write(16'h0114, 32'h0, 4'hF);
        reg_read("ch0 done_cnt cleared", 16'h0114, 32'd0);

        // Unmapped offsets
        reg_write(16'h0180, 32'hFFFFFFFF, 4'hF);
        reg_read("unmapped window c=NCH", 16'h0180, 32'h0);
        reg_read("unmapped 0x0FC", 16'h00FC, 32'h0);
        reg_read("unmapped window +0x18", 16'h0118, 32'h0);
        reg_write(16'h000C, 32'h0000_0005, 4'hF);
`ifdef RFSOC_CHAN_REGS_IRQ_COALESCE_EN
        reg_read("holdoff readback", 16'h000C, 32'h5);
`else
        reg_read("holdoff absent", 16'h000C, 32'h0);
`endif

        // Read and write in the same cycle returns the old value
        @(negedge clk);
        offset = 16'h0100;
        wdata  = 32'h11111111;
        wstrb  = 4'hF;
        wren   = 1'b1;
        rden   = 1'b1;
        exp_name.push_back("rw same cycle old value");
        exp_data.push_back(32'h0000BEEF);
        @(negedge clk);
        wren   = 1'b0;
        rden   = 1'b0;
        wstrb  = '0;
        reg_read("rw new value", 16'h0100, 32'h11111111);

`ifdef RFSOC_CHAN_REGS_IRQ_COALESCE_EN
        // Coalescing: HOLDOFF=5 delays irq six cycles after the done pulse
        @(negedge clk);
        ch_done[0] = 1'b1;
        @(negedge clk);
        ch_done[0] = 1'b0;
        irq_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            irq_seen = irq_seen | irq;
            @(negedge clk);
        end
        check("coalesce irq held off", {31'd0, irq_seen}, 32'd0);
        check("coalesce irq after holdoff", {31'd0, irq}, 32'd1);
        reg_write(16'h0008, 32'h1, 4'hF);
        @(negedge clk);
        check("coalesce irq cleared", {31'd0, irq}, 32'd0);
        // Clear during holdoff: irq never asserts
        @(negedge clk);
        ch_done[0] = 1'b1;
        @(negedge clk);
        ch_done[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        offset = 16'h0008;
        wdata  = 32'h1;
        wstrb  = 4'hF;
        wren   = 1'b1;
        @(negedge clk);
        wren   = 1'b0;
        wstrb  = '0;
        irq_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            irq_seen = irq_seen | irq;
        end
        check("coalesce cleared early", {31'd0, irq_seen}, 32'd0);
`else
        // Base latency: irq one cycle after the status bit
        @(negedge clk);
        ch_done[0] = 1'b1;
        @(negedge clk);
        ch_done[0] = 1'b0;
        check("irq latency not early", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq latency one cycle", {31'd0, irq}, 32'd1);
        reg_write(16'h0008, 32'h1, 4'hF);
        @(negedge clk);
`endif

        // Done counter saturation
        @(negedge clk);
        ch_done[3] = 1'b1;
        repeat (65540) @(negedge clk);
        ch_done[3] = 1'b0;
        reg_read("ch3 done_cnt saturates", 16'h0174, 32'h0000FFFF);

        // Asynchronous reset mid-capture
        reg_write(16'h0148, 32'h2, 4'h1);
        pulse_done(0);
        repeat (8) @(negedge clk);
        check("pre-reset irq", {31'd0, irq}, 32'd1);
        check("pre-reset ch_reset", {28'd0, ch_reset}, 32'h4);
        #2;
        rstb = 1'b0;
        #1;
        check("async rst irq", {31'd0, irq}, 32'd0);
        check("async rst ch_reset", {28'd0, ch_reset}, 32'd0);
        check("async rst rdata", rdata, 32'd0);
        check("async rst cfg ports", {31'd0, (|ch_start_addr) | (|ch_cap_size)}, 32'd0);
        check("async rst ch_start", {28'd0, ch_start}, 32'd0);

        repeat (2) @(negedge clk);
        check("scoreboard drained", 32'(exp_data.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
